frame_stream_reader: RTL and testbench

Streams a stored 8-bit greyscale frame out of a synchronous-read frame RAM as a raster pixel stream with a per-pixel advance strobe. Its output feeds the line-buffered separable Gaussian stages, which shift only on their clock-enable. After the last frame pixel it appends a run of zero pixels so the downstream line buffers drain completely. It is the transmit end of the pixel/clock-enable interface that the blur and DoG stages consume.

---
 rtl/frame_stream_reader.sv | 149 ++++++++++++++
 tb/tb_frame_stream_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_reader.sv
// Raster reader: frame RAM -> pixel stream with sof/eol/eof tags, then FLUSH_LEN zero pixels.
// Latency: start to first pixel is 3 cycles; one pixel per cycle while stall is low.
// Backpressure: stall gates dout_valid combinationally; a 2-entry skid FIFO absorbs in-flight RAM reads.
module frame_stream_reader #(
    parameter int WIDTH     = 400,
    parameter int HEIGHT    = 300,
    parameter int ADDR_W    = 17,
    parameter int FLUSH_LEN = 802
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              flush,
    output logic              busy,
    output logic              done
);
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int FL_W  = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(HEIGHT - 1);
    localparam logic [FL_W-1:0]   LAST_FL   = FL_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_all;
    logic              in_flight;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [FL_W-1:0]   fl_cnt;

    logic [7:0]        fifo_mem [2];
    logic              fifo_wp;
    logic              fifo_rp;
    logic [1:0]        fifo_count;
    logic [7:0]        fifo_head;

    logic              fifo_nonempty;
    logic              pix_xfer;
    logic              fl_xfer;
    logic              last_pix;
    logic              rd_go;
    logic [2:0]        level;

    assign fifo_nonempty = (fifo_count != 2'd0);
    assign fifo_head     = fifo_mem[fifo_rp];
    assign pix_xfer      = (state == S_READ) && fifo_nonempty && !stall;
    assign fl_xfer       = (state == S_FLUSH) && !stall;
    assign last_pix      = (row == LAST_ROW) && (col == LAST_COL);

    // Counting this cycle's pop lets a read issue alongside a transfer, keeping 1 pixel/cycle.
    assign level = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pix_xfer};
    assign rd_go = (state == S_READ) && !rd_all && (level < 3'd2);

    assign mem_rd     = rd_go;
    assign mem_addr   = rd_addr;
    assign dout       = ((state == S_READ) && fifo_nonempty) ? fifo_head : 8'd0;
    assign dout_valid = pix_xfer | fl_xfer;
    assign sof        = pix_xfer && (row == '0) && (col == '0);
    assign eol        = pix_xfer && (col == LAST_COL);
    assign eof        = pix_xfer && last_pix;
    assign flush      = fl_xfer;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (pix_xfer && last_pix) state_nxt = (FLUSH_LEN == 0) ? S_DONE : S_FLUSH;
            S_FLUSH: if (fl_xfer && (fl_cnt == LAST_FL)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_addr   <= '0;
            rd_all    <= 1'b0;
            in_flight <= 1'b0;
            col       <= '0;
            row       <= '0;
            fl_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            in_flight <= rd_go;
            if (state == S_IDLE) begin
                rd_addr <= '0;
                rd_all  <= 1'b0;
                col     <= '0;
                row     <= '0;
                fl_cnt  <= '0;
            end
            // Address holds at the last pixel so it never wraps past the frame.
            if (rd_go) begin
                if (rd_addr == LAST_ADDR) rd_all <= 1'b1;
                else                      rd_addr <= rd_addr + 1'b1;
            end
            if (pix_xfer) begin
                if (col == LAST_COL) begin
                    col <= '0;
                    row <= (row == LAST_ROW) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (fl_xfer) fl_cnt <= fl_cnt + 1'b1;
        end
    end

    // Skid FIFO control; reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wp    <= 1'b0;
            fifo_rp    <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (in_flight) fifo_wp <= ~fifo_wp;
            if (pix_xfer)  fifo_rp <= ~fifo_rp;
            fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pix_xfer};
        end
    end

    always_ff @(posedge clk) begin
        if (in_flight && !rst) fifo_mem[fifo_wp] <= mem_rdata;
    end
endmodule

// File: tb/tb_frame_stream_reader.sv
// Scoreboard bench: three readers (4x3 flush 10, 4x3 flush 0, 64x48 random stall) against RAM models.
module tb_frame_stream_reader;
    typedef struct {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
        logic       fl;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ram_val(input int g, input int i);
        return (g == 2) ? 8'((i * 13) ^ (i >> 6)) : 8'(i + 1);
    endfunction

    function automatic bit stall_at(input int m, input int r);
        return (m == 1) && (((r >= 5) && (r <= 8)) || ((r >= 16) && (r <= 17)));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int W  = (g == 2) ? 64 : 4;
        localparam int H  = (g == 2) ? 48 : 3;
        localparam int FL = (g == 0) ? 10 : ((g == 1) ? 0 : 2 * W + 2);
        localparam int N  = W * H;

        logic        rst = 1'b1;
        logic        start = 1'b0;
        logic        stall = 1'b0;
        logic        mem_rd;
        logic [16:0] mem_addr;
        logic [7:0]  mem_rdata;
        logic [7:0]  dout;
        logic        dout_valid, sof, eol, eof, flush, busy, done;

        exp_t q[$];
        int   t0 = 0;
        int   mode = 0;
        int   exp_done = -1;
        int   done_cnt = 0;
        int   frame_id = 0;
        int   seen_id = 0;
        int   rd_exp = 0;
        bit   repulse = 1'b0;
        bit   fin = 1'b0;

        frame_stream_reader #(
            .WIDTH(W), .HEIGHT(H), .ADDR_W(17), .FLUSH_LEN(FL)
        ) dut (
            .clk(clk), .rst(rst), .start(start), .stall(stall),
            .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
            .dout(dout), .dout_valid(dout_valid), .sof(sof), .eol(eol),
            .eof(eof), .flush(flush), .busy(busy), .done(done)
        );

        always @(posedge clk) if (mem_rd) mem_rdata <= ram_val(g, int'(mem_addr));

        function automatic string tag(input string s);
            return $sformatf("g%0d_%s", g, s);
        endfunction

        always @(negedge clk) begin
            exp_t e;
            if (seen_id != frame_id) begin
                seen_id = frame_id;
                rd_exp  = 0;
            end
            if (mem_rd) begin
                check_eq(tag("rd_addr"), 32'(mem_addr), rd_exp);
                rd_exp++;
            end
            if (dout_valid) begin
                check_eq(tag("xfer_in_stall"), 32'(stall), 0);
                check_eq(tag("pixel_expected"), 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check_eq(tag("dout"), 32'(dout), 32'(e.pix));
                    check_eq(tag("sof_eol_eof_flush"), 32'({sof, eol, eof, flush}),
                             32'({e.sof, e.eol, e.eof, e.fl}));
                    if (e.cyc >= 0) check_eq(tag("xfer_cycle"), cyc, e.cyc);
                end
            end else begin
                check_eq(tag("tags_when_invalid"), 32'({sof, eol, eof, flush}), 0);
            end
            if (done) begin
                done_cnt++;
                check_eq(tag("busy_at_done"), 32'(busy), 1);
                if (exp_done >= 0) check_eq(tag("done_cycle"), cyc, exp_done);
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
            if (mode == 2) stall = ($urandom_range(0, 99) < 30);
            else           stall = stall_at(mode, cyc - t0);
            start = repulse && ((cyc - t0 == 5) || (cyc - t0 == 20) || (cyc - t0 == 25));
        endtask

        task automatic push_frame(input int cnt);
            exp_t e;
            int   t = t0 + 3;
            for (int k = 0; k < cnt; k++) begin
                if (mode != 2) begin
                    while (stall_at(mode, t - t0)) t++;
                end
                e.pix = (k < N) ? ram_val(g, k) : 8'd0;
                e.sof = (k == 0);
                e.eol = (k < N) && ((k % W) == W - 1);
                e.eof = (k == N - 1);
                e.fl  = (k >= N);
                e.cyc = (mode == 2) ? -1 : t;
                q.push_back(e);
                t++;
            end
            exp_done = ((mode == 2) || (cnt != N + FL)) ? -1 : t;
        endtask

        task automatic check_quiet(input string s);
            check_eq(tag({s, "_addr"}), 32'(mem_addr), 0);
            check_eq(tag({s, "_outputs"}),
                     32'({mem_rd, dout, dout_valid, sof, eol, eof, flush, busy, done}), 0);
        endtask

        task automatic do_reset();
            rst = 1'b1;
            tick();
            tick();
            @(negedge clk);
            check_quiet("reset");
            rst = 1'b0;
            tick();
            @(negedge clk);
            check_quiet("idle");
        endtask

        // Leaves the bench at the negedge of cycle 1 of the new frame.
        task automatic launch(input int m, input int cnt);
            tick();
            mode = m;
            t0   = cyc;
            frame_id++;
            if (m != 2) stall = 1'b0;
            push_frame(cnt);
            start = 1'b1;
            tick();
            @(negedge clk);
            check_eq(tag("c1_busy"), 32'(busy), 1);
            check_eq(tag("c1_mem_rd"), 32'(mem_rd), 1);
            check_eq(tag("c1_mem_addr"), 32'(mem_addr), 0);
        endtask

        task automatic finish_frame(input int budget);
            int d0  = done_cnt;
            int lim = cyc + budget;
            while ((done_cnt == d0) && (cyc < lim)) tick();
            @(negedge clk);
            check_eq(tag("done_pulses"), done_cnt - d0, 1);
            check_eq(tag("queue_left"), q.size(), 0);
            check_eq(tag("busy_after_done"), 32'(busy), 0);
        endtask

        if (g == 0) begin : sc
            initial begin
                do_reset();
                launch(0, N + FL);
                finish_frame(200);
                launch(1, N + FL);
                finish_frame(200);
                // Reset lands in cycle 8: pixels 1..6 go out, the rest are abandoned.
                launch(0, 6);
                while (cyc < t0 + 8) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int c = 9; c <= 11; c++) begin
                    @(negedge clk);
                    check_quiet("mid_reset");
                    if (c < 11) tick();
                end
                check_eq(tag("aborted_frame_left"), q.size(), 0);
                launch(0, N + FL);
                finish_frame(200);
                repulse = 1'b1;
                launch(0, N + FL);
                finish_frame(200);
                repeat (10) tick();
                @(negedge clk);
                check_quiet("after_repulse");
                repulse = 1'b0;
                fin = 1'b1;
            end
        end else if (g == 1) begin : sc
            initial begin
                do_reset();
                launch(0, N);
                finish_frame(200);
                fin = 1'b1;
            end
        end else begin : sc
            initial begin
                do_reset();
                launch(2, N + FL);
                finish_frame(20000);
                fin = 1'b1;
            end
        end
    end

    initial begin
        while (!(gi[0].fin && gi[1].fin && gi[2].fin) && (cyc < 60000)) @(posedge clk);
        check_eq("all_scenarios_finished", 32'({gi[0].fin, gi[1].fin, gi[2].fin}), 32'd7);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
